fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage directly upstream of the decode stage. It owns the program counter and issues word reads on a single-outstanding request/acknowledge instruction port. Returned instructions land in a 2-entry output buffer that presents `o_instr`/`o_pc` with a valid/ready handshake to decode. A redirect from execute (branch/jump) flushes the buffer and discards any in-flight response.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] are ignored.
- `i_clk`  input  1  sole clock; all state updates on its rising edge.
- `i_rst`  input  1  reset, asynchronous and active-high.
- `o_imem_req`  output  1  instruction read request; registered.
- `o_imem_addr`  output  32  word-aligned read address, [1:0]=2'b00; registered, stable while `o_imem_req`=1.
- `i_imem_ack`  input  1  response strobe; only meaningful while `o_imem_req`=1; may assert in the same cycle the request rises.
- `i_imem_data`  input  32  instruction word, valid when `i_imem_ack`=1.
- `i_redirect`  input  1  single-cycle pulse: restart fetch at `i_redirect_pc`.
- `i_redirect_pc`  input  32  redirect target; bits [1:0] are forced to 0.
- `o_valid`  output  1  buffer head holds an instruction for decode.
- `o_instr`  output  32  head instruction.
- `o_pc`  output  32  address of the head instruction.
- `i_ready`  input  1  decode accepts the head this cycle; a pop occurs when `o_valid` & `i_ready`.

## Operation
- State: `fetch_pc` (next address to request), `pending` (request outstanding), `discard` (outstanding response is wrong-path), 2-entry FIFO of {instr, pc} with `count` 0..2.
- Issue rule: new request goes out at the edge when no request remains outstanding after that edge, and `count_next` + 1 ≤ 2. The buffer never overflows; acks arrive only when `count` ≤ 1 after any pop.
- On issue: `o_imem_req`←1, `o_imem_addr`←`fetch_pc`, `fetch_pc`←`fetch_pc`+4. The add is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
- Ack with `discard`=0: push {`i_imem_data`, `o_imem_addr`}. The request drops, or reissues the same edge per the issue rule.
- Ack with `discard`=1: data is dropped, `discard`←0, and the issue rule is applied using the redirected `fetch_pc`.
- FSM (derived from `pending`/`discard`):
  - IDLE: no request outstanding.
  - BUSY: request outstanding.
  - DRAIN: request outstanding and discarded.
  - Transitions: IDLE→BUSY on issue. BUSY→IDLE on ack with no reissue. BUSY→BUSY on ack with reissue. BUSY→DRAIN on redirect without ack. DRAIN→BUSY or IDLE on ack.
- Redirect at an edge:
  - FIFO cleared (`count`←0).
  - `fetch_pc`←{`i_redirect_pc`[31:2],2'b00}.
  - If a request is outstanding and not acked this cycle, enter DRAIN; `o_imem_req`/`o_imem_addr` are held until the ack.
  - If acked this same cycle, the response is dropped.
  - If IDLE, or acked this cycle, the redirect target is issued at this same edge.
- Redirect has priority over push and pop in the same cycle. A head popped in the redirect cycle is considered consumed; squashing it is downstream's concern.
- Redirect during DRAIN only updates `fetch_pc`.
- Simultaneous push and pop: `count` unchanged, FIFO order preserved.

## Timing
- Reset values:
  - `o_imem_req`=0, `o_imem_addr`=0.
  - `o_valid`=0, `o_instr`=32'h0000_0013 (NOP), `o_pc`=0.
  - `count`=0, `pending`=0, `discard`=0, `fetch_pc`=`RESET_PC`.
- Reset mid-request aborts everything. The memory is reset by the same `i_rst`.
- First request: `o_imem_req`=1 with `RESET_PC` after the first rising edge following `i_rst` deassertion.
- Fetch-to-decode latency: data acked at edge N is visible on `o_valid`/`o_instr` after edge N; zero-cycle combinational bypass is not allowed.
- Throughput: with a same-cycle-ack memory and `i_ready`=1, one instruction per cycle with no bubbles.
- Redirect latency: redirect at edge N in IDLE → request at the target after edge N; with same-cycle ack, `o_valid` with the target after edge N+1.
- During DRAIN, `o_valid` stays 0.
- `o_instr`/`o_pc` hold stable while `o_valid`=1 and `i_ready`=0.

## Test plan
- Reset release with `RESET_PC`=32'h100, zero-wait memory, `i_ready`=1 → `o_pc` = 0x100, 0x104, 0x108 on consecutive cycles; `o_valid` continuously 1.
- `i_ready`=0 for 5 cycles → exactly 2 instructions buffered, then `o_imem_req` falls. `o_instr`/`o_pc` hold. On release, the sequence resumes in order with no duplicate or missing pc.
- Memory ack delayed 3 cycles, redirect to 0x40 on the second wait cycle → the old response is dropped, `o_valid` stays 0 through the drain, and the next accepted pc is 0x40.
- Redirect in the same cycle as an ack for 0x200 → 0x200 never appears on `o_pc`; the next `o_pc` is the target.
- `RESET_PC`=32'hFFFF_FFF8 → `o_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `i_rst` while a request is outstanding and the buffer is full → `o_valid`=0 and `o_imem_req`=0 immediately. After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing single-outstanding instruction reads into a 2-entry decode buffer
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_ready
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
    state_t      state, state_next;
    logic [31:0] fetch_pc, base_pc;
    logic [31:0] buf_instr [2];
    logic [31:0] buf_pc [2];
    logic        rd_ptr;
    logic [1:0]  count, count_next;
    logic        ack, push, pop, outstanding, issue;
    assign o_valid = count != 2'd0;
    assign o_instr = buf_instr[rd_ptr];
    assign o_pc    = buf_pc[rd_ptr];
    // Handshake decode, buffer occupancy forecast and next fetch state; redirect overrides push/pop
    always_comb begin
        state_next  = state;
        ack         = i_imem_ack & (state != IDLE);
        pop         = o_valid & i_ready;
        push        = ack & (state == BUSY) & ~i_redirect;
        count_next  = i_redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
        outstanding = (state != IDLE) & ~ack;
        issue       = ~outstanding & (count_next < 2'd2);
        base_pc     = i_redirect ? (i_redirect_pc & ~32'd3) : fetch_pc;
        state_next  = outstanding ? ((state == DRAIN || i_redirect) ? DRAIN : BUSY)
                                  : (issue ? BUSY : IDLE);
    end
    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end
    // Request port and program counter; address is held while a request stays outstanding
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_imem_req  <= 1'b0;
            o_imem_addr <= 32'd0;
            fetch_pc    <= RESET_PC & ~32'd3;
        end else begin
            o_imem_req <= outstanding | issue;
            if (issue) begin
                o_imem_addr <= base_pc;
                fetch_pc    <= base_pc + 32'd4;
            end else if (i_redirect) begin
                fetch_pc <= base_pc;
            end
        end
    end
    // Output buffer: write slot follows the head by count, so a push into a full buffer reuses the popped slot
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count        <= 2'd0;
            rd_ptr       <= 1'b0;
            buf_instr[0] <= 32'h0000_0013;
            buf_instr[1] <= 32'h0000_0013;
            buf_pc[0]    <= 32'd0;
            buf_pc[1]    <= 32'd0;
        end else begin
            count  <= count_next;
            rd_ptr <= rd_ptr ^ pop;
            if (push) begin
                buf_instr[rd_ptr ^ count[0]] <= i_imem_data;
                buf_pc[rd_ptr ^ count[0]]    <= o_imem_addr;
            end
        end
    end
endmodule
